// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared state type and default widths for the clock-divider controller
package clkdiv_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  localparam int CNT_W_DEF = 8;
  localparam int BURST_W_DEF = 8;
endpackage

// File: rtl/clkdiv_phase_cnt.sv
// clkdiv_phase_cnt: loadable half-period down-counter; ports clk, rst (async low), load, en, load_val, zero
module clkdiv_phase_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en && cnt != '0) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/clkdiv_ctrl.sv
// clkdiv_ctrl: programmable divided clock with bursts/stop; ports clk, rst (async low), cfg_valid/cfg_ready/cfg_div/cfg_burst, stop, clk_out, tick, busy, done, period_cnt; CLKDIV_SHADOW_EN enables in-run reconfiguration
module clkdiv_ctrl import clkdiv_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF,
  parameter int BURST_W = BURST_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CNT_W-1:0]   cfg_div,
  input  logic [BURST_W-1:0] cfg_burst,
  input  logic               stop,
  output logic               clk_out,
  output logic               tick,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] period_cnt
);
  state_t state, state_n;
  logic [CNT_W-1:0] h, h_n, cfg_h, load_val;
  logic [BURST_W-1:0] b, b_n, pc_n, pc_inc;
  logic clk_out_n, tick_n, done_n, stop_pend, stop_pend_n;
  logic run, accept, zero, load, stop_any, burst_end;
  assign run = state == RUN;
  assign busy = run;
  assign accept = cfg_valid && cfg_ready;
  assign cfg_h = cfg_div == '0 ? CNT_W'(1) : cfg_div;
  assign pc_inc = period_cnt + 1'b1;
  assign stop_any = stop_pend || stop;
  assign burst_end = b != '0 && pc_inc == b;
`ifdef CLKDIV_SHADOW_EN
  logic sv, sv_n;
  logic [CNT_W-1:0] sh_h, sh_h_n;
  logic [BURST_W-1:0] sh_b, sh_b_n;
  assign cfg_ready = !run || !sv;
`else
  assign cfg_ready = !run;
`endif
  clkdiv_phase_cnt #(.W(CNT_W)) u_phase (
    .clk(clk), .rst(rst), .load(load), .en(run), .load_val(load_val), .zero(zero)
  );
  always_comb begin
    state_n = state;
    h_n = h;
    b_n = b;
    pc_n = period_cnt;
    clk_out_n = clk_out;
    tick_n = 1'b0;
    done_n = 1'b0;
    stop_pend_n = run && stop_any;
    load = 1'b0;
    load_val = h - 1'b1;
`ifdef CLKDIV_SHADOW_EN
    sv_n = sv;
    sh_h_n = sh_h;
    sh_b_n = sh_b;
    if (run && accept) begin
      sv_n = 1'b1;
      sh_h_n = cfg_h;
      sh_b_n = cfg_burst;
    end
`endif
    if (!run) begin
      if (accept) begin
        state_n = RUN;
        h_n = cfg_h;
        b_n = cfg_burst;
        pc_n = '0;
        clk_out_n = 1'b1;
        tick_n = 1'b1;
        load = 1'b1;
        load_val = cfg_h - 1'b1;
      end
    end else if (zero && clk_out) begin
      clk_out_n = 1'b0;
      load = 1'b1;
    end else if (zero) begin
      pc_n = pc_inc;
`ifdef CLKDIV_SHADOW_EN
      if (!stop_any && sv) begin
        h_n = sh_h;
        b_n = sh_b;
        pc_n = '0;
        clk_out_n = 1'b1;
        tick_n = 1'b1;
        load = 1'b1;
        load_val = sh_h - 1'b1;
        sv_n = 1'b0;
      end else
`endif
      if (stop_any || burst_end) begin
        state_n = IDLE;
        done_n = 1'b1;
        stop_pend_n = 1'b0;
      end else begin
        clk_out_n = 1'b1;
        tick_n = 1'b1;
        load = 1'b1;
      end
    end
`ifdef CLKDIV_SHADOW_EN
    if (state_n == IDLE) sv_n = 1'b0;
`endif
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      h <= '0;
      b <= '0;
      period_cnt <= '0;
      clk_out <= 1'b0;
      tick <= 1'b0;
      done <= 1'b0;
      stop_pend <= 1'b0;
    end else begin
      state <= state_n;
      h <= h_n;
      b <= b_n;
      period_cnt <= pc_n;
      clk_out <= clk_out_n;
      tick <= tick_n;
      done <= done_n;
      stop_pend <= stop_pend_n;
    end
`ifdef CLKDIV_SHADOW_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sv <= 1'b0;
      sh_h <= '0;
      sh_b <= '0;
    end else begin
      sv <= sv_n;
      sh_h <= sh_h_n;
      sh_b <= sh_b_n;
    end
`endif
endmodule

// File: doc/clkdiv_ctrl.md
# clkdiv_ctrl

Programmable clock-divider controller that sequences a divided square wave (clk_out) and tick strobes from the system clock under a valid/ready configuration handshake. It supports finite bursts of output periods and continuous running, and guarantees glitch-free start, stop and reconfiguration at period boundaries. It sits beside the fixed clkdiv2 divider and supersedes its hard-wired f2/f4/f8 taps wherever software-selected ratios or gated bursts are needed.

## Interface
- CNT_W, 8: width of half-period setting
- BURST_W, 8: width of burst length and period counter
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- cfg_valid  in  1  configuration offered
- cfg_ready  out  1  configuration can be accepted
- cfg_div  in  CNT_W  half-period H in clk cycles; 0 treated as 1
- cfg_burst  in  BURST_W  number of output periods B; 0 = continuous
- stop  in  1  request termination at next period boundary
- clk_out  out  1  divided clock, registered, period 2H, high first
- tick  out  1  one-cycle pulse in first cycle of each high phase
- busy  out  1  high while RUN
- done  out  1  one-cycle pulse on burst completion or stop
- period_cnt  out  BURST_W  completed periods since last accept, wraps

## Operation
- States: IDLE, RUN. Reset → IDLE; every output 0 except cfg_ready=1.
- IDLE: cfg_ready=1; stop ignored. Handshake (cfg_valid & cfg_ready at edge) loads H=max(cfg_div,1), B, clears period_cnt, enters RUN.
- RUN: cfg_ready=0 (unless CLKDIV_SHADOW_EN). Half-period down-counter reloads H-1; at each zero clk_out toggles.
- Period boundary = end of a low phase. At boundary: period_cnt+1. If (B≠0 and new count==B) or stop pending → IDLE, clk_out stays 0, done=1, busy=0. Else clk_out→1, tick=1.
- stop pulse of any length in RUN latches stop_pend; cleared on entry to IDLE.
- Stop and final burst period coinciding: single done pulse.
- H=1, 2, 4 reproduce f2, f4, f8 respectively.

## Timing
- Accept at edge k: cycle k+1 has clk_out=1, tick=1, busy=1.
- High H cycles, low H cycles; busy lasts exactly 2·H·B cycles for a burst.
- done and cfg_ready=1 in the cycle immediately after last low cycle; new accept possible in that same cycle.
- Reset asserted mid-run: all outputs to reset values asynchronously; no done.

## Configuration
- CLKDIV_SHADOW_EN defined: cfg_ready=1 also in RUN while shadow empty; accepted config held in shadow register, applied at next period boundary (new H, B, period_cnt cleared, clk_out→1 continues without IDLE gap). Stop at the same boundary wins; shadow discarded.
- Undefined: cfg_ready=0 throughout RUN; configs in RUN are not accepted.

## Structure
- Package clkdiv_pkg: state typedef (IDLE, RUN), default CNT_W/BURST_W constants.
- Sub-module clkdiv_phase_cnt: loadable half-period down-counter with zero flag.

## Test plan
- div=1, burst=4 → clk_out 1010 1010, 4 ticks, busy 8 cycles, done at k+9, period_cnt=4.
- div=4, burst=0, stop pulsed at k+5 → period completes at k+8, done at k+9, period_cnt=1.
- div=0, burst=2 → identical to div=1, burst=2 (busy 4 cycles).
- div=3, burst=5, rst low at k+7 → clk_out, tick, busy, done, period_cnt 0 immediately; cfg_ready=1; no done after release.
- cfg_valid in RUN with div=2: macro off → cfg_ready=0, ignored; macro on with new div=1 → high phase after next boundary lasts 1 cycle.
- div=2, burst=3, stop asserted during final period → exactly one done at k+13.
